fifo_2_axis_packetizer: RTL and testbench

FIFO_2_AXIS_PACKETIZER -- requirements
Module: fifo_2_axis_packetizer

---
 rtl/fifo_2_axis_packetizer.sv | 127 ++++++++++++
 tb/tb_fifo_2_axis_packetizer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_2_axis_packetizer.sv
// FIFO-to-AXI-Stream packetizer: pops a first-word-fall-through FIFO word,
// streams it out as RATIO narrower beats (LSB slice first), and frames the
// stream into packets of i_packet_len beats using tuser/tlast markers.
module fifo_2_axis_packetizer #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int RATIO           = 1,
  parameter int FIFO_DATA_WIDTH = AXIS_DATA_WIDTH * RATIO,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_enable,
  input  logic [LEN_WIDTH-1:0]       i_packet_len,
  input  logic [FIFO_DATA_WIDTH-1:0] i_fifo_data,
  input  logic                       i_fifo_not_empty,
  output logic                       o_fifo_r_stb,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_tdata,
  output logic                       o_axis_tvalid,
  input  logic                       i_axis_tready,
  output logic                       o_axis_tuser,
  output logic                       o_axis_tlast,
  output logic [31:0]                o_packet_count
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  typedef enum logic {EMPTY, SEND} state_t;

  state_t                     state_q, state_d;
  logic [FIFO_DATA_WIDTH-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [LEN_WIDTH-1:0]       beat_cnt_q, beat_cnt_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d;
  logic [31:0]                pkt_cnt_q, pkt_cnt_d;

  logic                       tvalid;
  logic                       hs;
  logic                       last_sub;
  logic                       pop;
  logic                       tlast;
  logic [LEN_WIDTH-1:0]       eff_len;

  // Handshake, pop strobe and packet framing decode.
  // Length is sampled live at the first beat of a packet and latched there,
  // so mid-packet length changes never move the current packet's end.
  always_comb begin
    tvalid   = (state_q == SEND);
    hs       = tvalid & i_axis_tready;
    last_sub = (idx_q == LAST_IDX);
    pop      = i_rstn & i_fifo_not_empty & i_enable &
               ((state_q == EMPTY) | (hs & last_sub));
    eff_len  = (beat_cnt_q == '0) ? i_packet_len : len_q;
    tlast    = tvalid & (eff_len != '0) &
               (beat_cnt_q == eff_len - LEN_WIDTH'(1));
  end

  // Output slice select from the registered buffer, plus marker outputs.
  always_comb begin
    o_axis_tdata = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (idx_q == IDX_W'(k)) begin
        o_axis_tdata = buf_q[k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
      end
    end
    o_axis_tvalid  = tvalid;
    o_fifo_r_stb   = pop;
    o_axis_tuser   = tvalid & (beat_cnt_q == '0);
    o_axis_tlast   = tlast;
    o_packet_count = pkt_cnt_q;
  end

  // Next-state: buffer load on pop, sub-beat advance on handshake, framing counters.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    pkt_cnt_d  = pkt_cnt_q;

    if (pop) begin
      buf_d   = i_fifo_data;
      idx_d   = '0;
      state_d = SEND;
    end else if (hs) begin
      if (last_sub) begin
        idx_d   = '0;
        state_d = EMPTY;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (hs) begin
      if (beat_cnt_q == '0) begin
        len_d = i_packet_len;
      end
      if (tlast) begin
        beat_cnt_d = '0;
        pkt_cnt_d  = pkt_cnt_q + 32'd1;
      end else begin
        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= EMPTY;
      buf_q      <= '0;
      idx_q      <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      idx_q      <= idx_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_2_axis_packetizer.sv
// Directed bench: three packetizer instances (RATIO 1, 2, 4) fed by simple
// FWFT FIFO models; handshaked beats are logged and compared to constants.
module tb_fifo_2_axis_packetizer;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         u;
    logic         l;
    int unsigned  c;
  } beat_t;

  // ---------------- instance A : RATIO=1 ----------------
  logic [W-1:0]   mem_a [16];
  int unsigned    wr_a = 0, rd_a = 0;
  logic           en_a, ne_a, stb_a, tv_a, tr_a, tu_a, tl_a;
  logic [15:0]    len_a;
  logic [W-1:0]   fd_a, td_a;
  logic [31:0]    pk_a;
  assign ne_a = (rd_a != wr_a);
  assign fd_a = mem_a[rd_a % 16];
  always @(posedge clk) if (stb_a) rd_a <= rd_a + 1;

  fifo_2_axis_packetizer #(.AXIS_DATA_WIDTH(W), .RATIO(1)) u_a (
    .i_clk(clk), .i_rstn(rstn), .i_enable(en_a), .i_packet_len(len_a),
    .i_fifo_data(fd_a), .i_fifo_not_empty(ne_a), .o_fifo_r_stb(stb_a),
    .o_axis_tdata(td_a), .o_axis_tvalid(tv_a), .i_axis_tready(tr_a),
    .o_axis_tuser(tu_a), .o_axis_tlast(tl_a), .o_packet_count(pk_a));

  // ---------------- instance B : RATIO=2 ----------------
  logic [2*W-1:0] mem_b [16];
  int unsigned    wr_b = 0, rd_b = 0;
  logic           en_b, ne_b, stb_b, tv_b, tr_b, tu_b, tl_b;
  logic [15:0]    len_b;
  logic [2*W-1:0] fd_b;
  logic [W-1:0]   td_b;
  logic [31:0]    pk_b;
  assign ne_b = (rd_b != wr_b);
  assign fd_b = mem_b[rd_b % 16];
  always @(posedge clk) if (stb_b) rd_b <= rd_b + 1;

  fifo_2_axis_packetizer #(.AXIS_DATA_WIDTH(W), .RATIO(2)) u_b (
    .i_clk(clk), .i_rstn(rstn), .i_enable(en_b), .i_packet_len(len_b),
    .i_fifo_data(fd_b), .i_fifo_not_empty(ne_b), .o_fifo_r_stb(stb_b),
    .o_axis_tdata(td_b), .o_axis_tvalid(tv_b), .i_axis_tready(tr_b),
    .o_axis_tuser(tu_b), .o_axis_tlast(tl_b), .o_packet_count(pk_b));

  // ---------------- instance C : RATIO=4 ----------------
  logic [4*W-1:0] mem_c [16];
  int unsigned    wr_c = 0, rd_c = 0;
  logic           en_c, ne_c, stb_c, tv_c, tr_c, tu_c, tl_c;
  logic [15:0]    len_c;
  logic [4*W-1:0] fd_c;
  logic [W-1:0]   td_c;
  logic [31:0]    pk_c;
  assign ne_c = (rd_c != wr_c);
  assign fd_c = mem_c[rd_c % 16];
  always @(posedge clk) if (stb_c) rd_c <= rd_c + 1;

  fifo_2_axis_packetizer #(.AXIS_DATA_WIDTH(W), .RATIO(4)) u_c (
    .i_clk(clk), .i_rstn(rstn), .i_enable(en_c), .i_packet_len(len_c),
    .i_fifo_data(fd_c), .i_fifo_not_empty(ne_c), .o_fifo_r_stb(stb_c),
    .o_axis_tdata(td_c), .o_axis_tvalid(tv_c), .i_axis_tready(tr_c),
    .o_axis_tuser(tu_c), .o_axis_tlast(tl_c), .o_packet_count(pk_c));

  // Beat / pop logger: inputs only change just after posedge, so negedge
  // values are exactly what the next posedge will see.
  beat_t qa[$], qb[$], qc[$];
  int unsigned pops_b = 0, pops_c = 0;
  always @(negedge clk) begin
    if (tv_a && tr_a) qa.push_back('{d: td_a, u: tu_a, l: tl_a, c: cyc});
    if (tv_b && tr_b) qb.push_back('{d: td_b, u: tu_b, l: tl_b, c: cyc});
    if (tv_c && tr_c) qc.push_back('{d: td_c, u: tu_c, l: tl_c, c: cyc});
    if (stb_b) pops_b <= pops_b + 1;
    if (stb_c) pops_c <= pops_c + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int unsigned  ba, bb, bc, pb, pc;
  logic         stalled;
  logic [W-1:0] snap_d;
  logic         snap_u, snap_l;

  initial begin
    rstn = 1'b0;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    tr_a = 1'b0; tr_b = 1'b0; tr_c = 1'b0;
    len_a = 16'd4; len_b = 16'd2; len_c = 16'd6;
    mem_a[0] = 32'h10; wr_a = 1;

    // Reset: outputs quiet and no pop although A's FIFO is non-empty
    tick(3);
    chk("rst_tvalid", tv_a, 1'b0);
    chk("rst_tuser", tu_a, 1'b0);
    chk("rst_tlast", tl_a, 1'b0);
    chk("rst_tdata", td_a, 32'h0);
    chk("rst_stb", stb_a, 1'b0);
    chk("rst_pktcnt", pk_a, 32'd0);
    chk("rst_tvalid_c", tv_c, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rel_stb", stb_a, 1'b1);
    tick(1);
    chk("first_tvalid", tv_a, 1'b1);
    chk("first_tdata", td_a, 32'h10);
    chk("first_tuser", tu_a, 1'b1);

    // RATIO=1, len=4, 8 words back to back
    ba = qa.size();
    for (int i = 1; i < 8; i++) begin
      mem_a[wr_a % 16] = 32'h10 + i;
      wr_a++;
    end
    tr_a = 1'b1;
    tick(10);
    chk("a036_nbeats", qa.size() - ba, 8);
    for (int i = 0; i < 8; i++) begin
      chk("a036_data", qa[ba+i].d, 32'h10 + i);
      chk("a036_tuser", qa[ba+i].u, (i % 4) == 0);
      chk("a036_tlast", qa[ba+i].l, (i % 4) == 3);
    end
    chk("a036_gapless", qa[ba+7].c - qa[ba].c, 7);
    chk("a036_pktcnt", pk_a, 32'd2);
    chk("a036_idle", tv_a, 1'b0);

    // RATIO=2, tready toggling: stability during stalls, order, pop rate
    bb = qb.size();
    pb = pops_b;
    mem_b[0] = 64'h00000002_00000001;
    mem_b[1] = 64'h00000004_00000003;
    mem_b[2] = 64'h00000006_00000005;
    wr_b = 3;
    stalled = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (stalled) begin
        chk("b038_hold_tdata", td_b, snap_d);
        chk("b038_hold_tuser", tu_b, snap_u);
        chk("b038_hold_tlast", tl_b, snap_l);
      end
      tr_b = ((i % 2) == 0);
      #1;
      stalled = tv_b && !tr_b;
      snap_d = td_b; snap_u = tu_b; snap_l = tl_b;
      tick(1);
    end
    chk("b038_nbeats", qb.size() - bb, 6);
    for (int i = 0; i < 6; i++) begin
      chk("b038_data", qb[bb+i].d, 32'h1 + i);
      chk("b038_tuser", qb[bb+i].u, (i % 2) == 0);
      chk("b038_tlast", qb[bb+i].l, (i % 2) == 1);
    end
    chk("b038_pops", pops_b - pb, 3);
    chk("b038_pktcnt", pk_b, 32'd3);

    // RATIO=4, len=6: disable mid-word, framing continues after re-enable
    bc = qc.size();
    pc = pops_c;
    mem_c[0] = {32'h04, 32'h03, 32'h02, 32'h01};
    mem_c[1] = {32'h08, 32'h07, 32'h06, 32'h05};
    wr_c = 2;
    tick(2);
    chk("c040_tvalid", tv_c, 1'b1);
    tr_c = 1'b1;
    tick(2);
    en_c = 1'b0;
    tick(6);
    chk("c040_drained_beats", qc.size() - bc, 4);
    chk("c040_drained_tvalid", tv_c, 1'b0);
    chk("c040_no_stb", stb_c, 1'b0);
    chk("c040_one_pop", pops_c - pc, 1);
    en_c = 1'b1;
    #1;
    chk("c040_reen_stb", stb_c, 1'b1);
    tick(6);
    chk("c040_nbeats", qc.size() - bc, 8);
    for (int i = 0; i < 8; i++) begin
      chk("c040_data", qc[bc+i].d, 32'h1 + i);
      chk("c040_tuser", qc[bc+i].u, (i == 0) || (i == 6));
      chk("c040_tlast", qc[bc+i].l, i == 5);
    end
    chk("c040_pktcnt", pk_c, 32'd1);

    // RATIO=1, len=1: every beat is a full packet
    ba = qa.size();
    len_a = 16'd1;
    for (int i = 0; i < 3; i++) begin
      mem_a[wr_a % 16] = 32'h20 + i;
      wr_a++;
    end
    tick(6);
    chk("a039_len1_nbeats", qa.size() - ba, 3);
    for (int i = 0; i < 3; i++) begin
      chk("a039_len1_tuser", qa[ba+i].u, 1'b1);
      chk("a039_len1_tlast", qa[ba+i].l, 1'b1);
    end
    chk("a039_len1_pktcnt", pk_a, 32'd5);

    // len 3 -> 5 after the first beat: packet still ends on its third beat
    ba = qa.size();
    tr_a = 1'b0;
    len_a = 16'd3;
    for (int i = 0; i < 4; i++) begin
      mem_a[wr_a % 16] = 32'h30 + i;
      wr_a++;
    end
    tick(2);
    tr_a = 1'b1;
    tick(1);
    tr_a = 1'b0;
    len_a = 16'd5;
    tick(1);
    tr_a = 1'b1;
    tick(5);
    chk("a039_chg_nbeats", qa.size() - ba, 4);
    chk("a039_chg_data3", qa[ba+3].d, 32'h33);
    chk("a039_chg_tlast_b1", qa[ba+1].l, 1'b0);
    chk("a039_chg_tlast_b2", qa[ba+2].l, 1'b1);
    chk("a039_chg_tuser_b3", qa[ba+3].u, 1'b1);
    chk("a039_chg_tlast_b3", qa[ba+3].l, 1'b0);
    chk("a039_chg_pktcnt", pk_a, 32'd6);

    // Reset mid-packet with tvalid=1
    tr_a = 1'b0;
    mem_a[wr_a % 16] = 32'h40; wr_a++;
    mem_a[wr_a % 16] = 32'h41; wr_a++;
    tick(2);
    chk("a041_pre_tvalid", tv_a, 1'b1);
    chk("a041_pre_tuser", tu_a, 1'b0);
    rstn = 1'b0;
    #1;
    chk("a041_rst_tvalid", tv_a, 1'b0);
    chk("a041_rst_tuser", tu_a, 1'b0);
    chk("a041_rst_tlast", tl_a, 1'b0);
    chk("a041_rst_pktcnt", pk_a, 32'd0);
    chk("a041_rst_stb", stb_a, 1'b0);
    chk("a041_rst_pktcnt_c", pk_c, 32'd0);
    len_c = 16'd0;
    @(negedge clk);
    rstn = 1'b1;
    tick(2);
    chk("a041_post_tvalid", tv_a, 1'b1);
    chk("a041_post_tdata", td_a, 32'h41);
    chk("a041_post_tuser", tu_a, 1'b1);

    // RATIO=4, len=0: slices LSB first, one pop, no tlast, tuser only first
    bc = qc.size();
    pc = pops_c;
    mem_c[wr_c % 16] = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    wr_c++;
    tick(7);
    chk("c037_nbeats", qc.size() - bc, 4);
    chk("c037_data0", qc[bc].d, 32'hAAAAAAAA);
    chk("c037_data1", qc[bc+1].d, 32'hBBBBBBBB);
    chk("c037_data2", qc[bc+2].d, 32'hCCCCCCCC);
    chk("c037_data3", qc[bc+3].d, 32'hDDDDDDDD);
    for (int i = 0; i < 4; i++) begin
      chk("c037_tuser", qc[bc+i].u, i == 0);
      chk("c037_tlast", qc[bc+i].l, 1'b0);
    end
    chk("c037_gapless", qc[bc+3].c - qc[bc].c, 3);
    chk("c037_pops", pops_c - pc, 1);
    chk("c037_pktcnt", pk_c, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
